// File: rtl/ram_seq_pkg.sv
// Shared types and default sizes for the RAM burst sequencer.
package ram_seq_pkg;
  localparam int AW_DEF = 4;
  localparam int DW_DEF = 8;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR_LOAD  = 3'd1,
    WR_DRIVE = 3'd2,
    RD       = 3'd3,
    TURN     = 3'd4
  } state_e;
endpackage

// File: rtl/ram_seq_ctrl_if.sv
// Host-side request, write-beat and read-stream signals of the sequencer.
interface ram_seq_ctrl_if
  import ram_seq_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) ();
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [AW-1:0] req_addr;
  logic [AW-1:0] req_len;
  logic [DW-1:0] wr_data;
  logic          wr_valid;
  logic          wr_ready;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          busy;
  logic          done;

  modport master (
    output req_valid, req_write, req_addr, req_len, wr_data, wr_valid,
    input  req_ready, wr_ready, rd_data, rd_valid, busy, done
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_len, wr_data, wr_valid,
    output req_ready, wr_ready, rd_data, rd_valid, busy, done
  );
endinterface

// File: rtl/ram_addr_gen.sv
// Burst address register with natural wrap plus remaining-beat down-counter.
module ram_addr_gen #(
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          step,
  input  logic [AW-1:0] ld_addr,
  input  logic [AW-1:0] ld_len,
  output logic [AW-1:0] addr,
  output logic          last
);
  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] cnt_q, cnt_d;

  always_comb begin
    addr_d = addr_q;
    cnt_d  = cnt_q;
    if (load) begin
      addr_d = ld_addr;
      cnt_d  = ld_len;
    end else if (step) begin
      // Wrap from the top word back to 0 falls out of the AW-bit add.
      addr_d = addr_q + 1'b1;
      if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      cnt_q  <= '0;
    end else begin
      addr_q <= addr_d;
      cnt_q  <= cnt_d;
    end
  end

  assign addr = addr_q;
  assign last = (cnt_q == '0);
endmodule

// File: rtl/ram_seq_ctrl.sv
// Burst sequencer for a single-port RAM on a shared tri-state bus; all strobes
// are registered from the next state so they line up exactly with the state.
module ram_seq_ctrl
  import ram_seq_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  ram_seq_ctrl_if.slave  host,
  output logic           ram_cs,
  output logic           ram_oa,
  output logic           ram_wa,
  output logic [AW-1:0]  ram_addr,
  inout  wire  [DW-1:0]  ram_bus
);
  state_e        state_q, state_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rd_data_q, rd_data_d;
  logic          rd_valid_q, rd_valid_d;
  logic          done_q, done_d;
  logic          req_ready_q, req_ready_d;
  logic          wr_ready_q, wr_ready_d;
  logic          busy_q, busy_d;
  logic          cs_q, cs_d;
  logic          oa_q, oa_d;
  logic          wa_q, wa_d;
  logic          bus_oe_q, bus_oe_d;
  logic          ag_load, ag_step, ag_last;
  logic [AW-1:0] ag_addr;

  ram_addr_gen #(.AW(AW)) u_addr_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (ag_load),
    .step    (ag_step),
    .ld_addr (host.req_addr),
    .ld_len  (host.req_len),
    .addr    (ag_addr),
    .last    (ag_last)
  );

  always_comb begin
    state_d   = state_q;
    wdata_d   = wdata_q;
    rd_data_d = rd_data_q;
    ag_load   = 1'b0;
    ag_step   = 1'b0;
    case (state_q)
      IDLE: if (host.req_valid && req_ready_q) begin
        ag_load = 1'b1;
        state_d = host.req_write ? WR_LOAD : RD;
      end
      WR_LOAD: if (host.wr_valid && wr_ready_q) begin
        wdata_d = host.wr_data;
        state_d = WR_DRIVE;
      end
      WR_DRIVE: begin
        ag_step = 1'b1;
        state_d = ag_last ? TURN : WR_LOAD;
      end
      RD: begin
        ag_step   = 1'b1;
        rd_data_d = ram_bus;
        state_d   = ag_last ? TURN : RD;
      end
      TURN:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Moore decode of the upcoming state; TURN keeps every strobe low for turnaround.
    cs_d        = (state_d == WR_DRIVE) || (state_d == RD);
    wa_d        = (state_d == WR_DRIVE);
    oa_d        = (state_d == RD);
    bus_oe_d    = (state_d == WR_DRIVE);
    req_ready_d = (state_d == IDLE);
    wr_ready_d  = (state_d == WR_LOAD);
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == TURN);
    rd_valid_d  = (state_q == RD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wdata_q     <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      done_q      <= 1'b0;
      req_ready_q <= 1'b0;
      wr_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      cs_q        <= 1'b0;
      oa_q        <= 1'b0;
      wa_q        <= 1'b0;
      bus_oe_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      wdata_q     <= wdata_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      done_q      <= done_d;
      req_ready_q <= req_ready_d;
      wr_ready_q  <= wr_ready_d;
      busy_q      <= busy_d;
      cs_q        <= cs_d;
      oa_q        <= oa_d;
      wa_q        <= wa_d;
      bus_oe_q    <= bus_oe_d;
    end
  end

  assign ram_bus       = bus_oe_q ? wdata_q : {DW{1'bz}};
  assign ram_cs        = cs_q;
  assign ram_oa        = oa_q;
  assign ram_wa        = wa_q;
  assign ram_addr      = ag_addr;
  assign host.req_ready = req_ready_q;
  assign host.wr_ready  = wr_ready_q;
  assign host.rd_data   = rd_data_q;
  assign host.rd_valid  = rd_valid_q;
  assign host.busy      = busy_q;
  assign host.done      = done_q;
endmodule

// File: tb/tb_ram_seq_ctrl.sv
// Bench for ram_seq_ctrl: behavioural 16x8 RAM on the shared bus, a word-level
// reference memory, scenario tasks and a per-cycle strobe/bus invariant monitor.
module tb_ram_seq_ctrl;
  import ram_seq_pkg::*;
  localparam int AW = 4;
  localparam int DW = 8;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ram_seq_ctrl_if #(.AW(AW), .DW(DW)) hif ();
  logic          ram_cs, ram_oa, ram_wa;
  logic [AW-1:0] ram_addr;
  wire  [DW-1:0] ram_bus;

  ram_seq_ctrl #(.AW(AW), .DW(DW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .host     (hif.slave),
    .ram_cs   (ram_cs),
    .ram_oa   (ram_oa),
    .ram_wa   (ram_wa),
    .ram_addr (ram_addr),
    .ram_bus  (ram_bus)
  );

  // Behavioural RAM: asynchronous read onto the bus, write on the clock edge.
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] ref_mem [DEPTH];
  assign ram_bus = (ram_cs && ram_oa) ? mem[ram_addr] : {DW{1'bz}};
  always @(posedge clk) if (ram_cs && ram_wa) mem[ram_addr] <= ram_bus;

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;
  int rdv_cnt  = 0;

  logic [DW-1:0] wr_q[$];
  logic [DW-1:0] rd_got[$];
  int            rd_idx[$];

  always @(negedge clk) begin
    if (hif.done) done_cnt++;
    if (hif.rd_valid) rdv_cnt++;
    n_tests++;
    if ((ram_wa && ram_oa) || ((ram_wa || ram_oa) && !ram_cs) ||
        (ram_oa && ram_bus !== mem[ram_addr])) begin
      n_fail++;
      $display("FAIL invariant t=%0t cs=%b oa=%b wa=%b bus=%h ram_word=%h",
               $time, ram_cs, ram_oa, ram_wa, ram_bus, mem[ram_addr]);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic handshake(input bit wr, input logic [AW-1:0] a, input logic [AW-1:0] l);
    int t = 0;
    hif.req_valid = 1'b1; hif.req_write = wr; hif.req_addr = a; hif.req_len = l;
    while (!hif.req_ready && t < 64) begin @(negedge clk); t++; end
    n_tests++;
    if (!hif.req_ready) begin n_fail++; $display("FAIL req_handshake: req_ready=0 required 1 after %0d cycles", t); end
    @(negedge clk);
    hif.req_valid = 1'b0;
  endtask

  // Writes wr_q[0..l] starting at a; gap idle cycles before each beat.
  task automatic do_write(input logic [AW-1:0] a, input logic [AW-1:0] l, input int gap,
                          output int gap_viol);
    int t;
    logic [AW-1:0] ea;
    gap_viol = 0;
    handshake(1'b1, a, l);
    for (int b = 0; b <= int'(l); b++) begin
      hif.wr_valid = 1'b0;
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        if (hif.wr_ready && (ram_cs || ram_wa || ram_oa)) gap_viol++;
      end
      hif.wr_valid = 1'b1; hif.wr_data = wr_q[b]; t = 0;
      while (!hif.wr_ready && t < 64) begin @(negedge clk); t++; end
      @(negedge clk);
      hif.wr_valid = 1'b0;
      ea = AW'(int'(a) + b);
      n_tests++;
      if (!(ram_cs && ram_wa && !ram_oa && ram_bus === wr_q[b] && ram_addr === ea)) begin
        n_fail++;
        $display("FAIL wr_drive beat %0d: cs=%b wa=%b oa=%b addr=%h bus=%h required 1/1/0 addr=%h bus=%h",
                 b, ram_cs, ram_wa, ram_oa, ram_addr, ram_bus, ea, wr_q[b]);
      end
      ref_mem[ea] = wr_q[b];
    end
    t = 0;
    while (hif.busy && t < 64) begin @(negedge clk); t++; end
    n_tests++;
    if (hif.busy) begin n_fail++; $display("FAIL wr_finish: busy=1 required 0"); end
  endtask

  // Collects rd_valid beats and the cycle (relative to acceptance) they appear in.
  task automatic do_read(input logic [AW-1:0] a, input logic [AW-1:0] l);
    int n = 1;
    bit seen = 1'b0;
    rd_got = {}; rd_idx = {};
    handshake(1'b0, a, l);
    while (n < 64) begin
      if (hif.rd_valid) begin rd_got.push_back(hif.rd_data); rd_idx.push_back(n); end
      if (hif.done) begin seen = 1'b1; break; end
      @(negedge clk); n++;
    end
    n_tests++;
    if (!seen) begin n_fail++; $display("FAIL rd_done: done never seen within %0d cycles", n); end
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_tests++;
    if ({hif.req_ready, hif.wr_ready, hif.rd_valid, hif.busy, hif.done, ram_cs, ram_oa, ram_wa} !== 8'h00 ||
        ram_addr !== '0 || hif.rd_data !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: rdy=%b wrdy=%b rdv=%b busy=%b done=%b cs=%b oa=%b wa=%b addr=%h rdata=%h required all 0",
               hif.req_ready, hif.wr_ready, hif.rd_valid, hif.busy, hif.done, ram_cs, ram_oa, ram_wa, ram_addr, hif.rd_data);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if (hif.req_ready !== 1'b1 || hif.busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_idle: req_ready=%b busy=%b required 1 0", hif.req_ready, hif.busy);
    end
  endtask

  task automatic test_single();
    int gv; int dc0 = done_cnt;
    wr_q = {8'hA5};
    do_write(4'd3, 4'd0, 0, gv);
    n_tests++;
    if (mem[3] !== 8'hA5) begin n_fail++; $display("FAIL single_store: ram[3]=%h required a5", mem[3]); end
    do_read(4'd3, 4'd0);
    n_tests++;
    if (rd_got.size() != 1 || rd_got[0] !== 8'hA5 || rd_idx[0] != 2) begin
      n_fail++; $display("FAIL single_read: beats=%0d data=%h cycle=%0d required 1 a5 2",
                         rd_got.size(), rd_got.size() ? rd_got[0] : 8'h0, rd_idx.size() ? rd_idx[0] : -1);
    end
    n_tests++;
    if (done_cnt - dc0 != 2) begin n_fail++; $display("FAIL single_done: pulses=%0d required 2", done_cnt - dc0); end
  endtask

  task automatic test_wrap();
    int gv;
    logic [DW-1:0] exp_seq[4];
    exp_seq = '{8'h11, 8'h22, 8'h33, 8'h44};
    wr_q = {8'h11, 8'h22, 8'h33, 8'h44};
    do_write(4'd14, 4'd3, 0, gv);
    n_tests++;
    if (mem[14] !== 8'h11 || mem[15] !== 8'h22 || mem[0] !== 8'h33 || mem[1] !== 8'h44) begin
      n_fail++; $display("FAIL wrap_store: ram[14,15,0,1]=%h %h %h %h required 11 22 33 44", mem[14], mem[15], mem[0], mem[1]);
    end
    do_read(4'd14, 4'd3);
    n_tests++;
    if (rd_got.size() != 4) begin
      n_fail++; $display("FAIL wrap_read_len: beats=%0d required 4", rd_got.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_tests++;
        if (rd_got[i] !== exp_seq[i] || rd_idx[i] != 2 + i) begin
          n_fail++; $display("FAIL wrap_read beat %0d: data=%h cycle=%0d required %h %0d", i, rd_got[i], rd_idx[i], exp_seq[i], 2 + i);
        end
      end
    end
  endtask

  task automatic test_gaps();
    int gv; int dc0 = done_cnt;
    logic [AW-1:0] a = AW'($urandom_range(0, DEPTH - 1));
    wr_q = {};
    for (int i = 0; i < 3; i++) wr_q.push_back(DW'($urandom));
    do_write(a, 4'd2, 3, gv);
    n_tests++;
    if (gv != 0) begin n_fail++; $display("FAIL gap_strobes: active-strobe cycles=%0d required 0", gv); end
    n_tests++;
    if (done_cnt - dc0 != 1) begin n_fail++; $display("FAIL gap_done: pulses=%0d required 1", done_cnt - dc0); end
    do_read(a, 4'd2);
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (rd_got.size() != 3 || rd_got[i] !== ref_mem[AW'(int'(a) + i)]) begin
        n_fail++; $display("FAIL gap_read beat %0d: beats=%0d data=%h required %h", i, rd_got.size(),
                           rd_got.size() > i ? rd_got[i] : 8'h0, ref_mem[AW'(int'(a) + i)]);
      end
    end
  endtask

  task automatic test_ignore_wr();
    int bad = 0;
    hif.wr_valid = 1'b1;
    repeat (4) begin hif.wr_data = DW'($urandom); @(negedge clk); end
    hif.wr_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== ref_mem[i]) bad++;
    n_tests++;
    if (bad != 0 || hif.busy !== 1'b0) begin
      n_fail++; $display("FAIL idle_wr_ignored: changed words=%0d busy=%b required 0 0", bad, hif.busy);
    end
  endtask

  task automatic test_full_busy();
    int gv; int n = 1; int viol = 0; int t = 0; int rdv0;
    logic [AW-1:0] s = AW'($urandom_range(0, DEPTH - 1));
    wr_q = {};
    for (int i = 0; i < DEPTH; i++) wr_q.push_back(DW'($urandom));
    do_write(s, 4'd15, 0, gv);
    rdv0 = rdv_cnt;
    rd_got = {};
    hif.req_valid = 1'b1; hif.req_write = 1'b0; hif.req_addr = s; hif.req_len = 4'd15;
    while (!hif.req_ready && t < 64) begin @(negedge clk); t++; end
    @(negedge clk);
    while (n < 64) begin
      if (hif.req_ready) viol++;
      if (hif.rd_valid) rd_got.push_back(hif.rd_data);
      if (hif.done) break;
      @(negedge clk); n++;
    end
    n_tests++;
    if (rd_got.size() != 16 || viol != 0) begin
      n_fail++; $display("FAIL held_req_first: beats=%0d ready-while-busy=%0d required 16 0", rd_got.size(), viol);
    end
    for (int i = 0; i < DEPTH; i++) begin
      n_tests++;
      if (rd_got.size() != 16 || rd_got[i] !== ref_mem[AW'(int'(s) + i)]) begin
        n_fail++; $display("FAIL full_read beat %0d: data=%h required %h", i,
                           rd_got.size() > i ? rd_got[i] : 8'h0, ref_mem[AW'(int'(s) + i)]);
      end
    end
    @(negedge clk);
    @(negedge clk);
    hif.req_valid = 1'b0;
    n_tests++;
    if (hif.busy !== 1'b1) begin n_fail++; $display("FAIL held_req_second: busy=%b required 1", hif.busy); end
    t = 0;
    while (!hif.done && t < 64) begin @(negedge clk); t++; end
    @(negedge clk);
    n_tests++;
    if (rdv_cnt - rdv0 != 32) begin n_fail++; $display("FAIL held_req_total: rd_valid pulses=%0d required 32", rdv_cnt - rdv0); end
  endtask

  task automatic test_reset_mid();
    int t; int dc0;
    logic [AW-1:0] a = AW'($urandom_range(0, DEPTH - 1));
    logic [AW-1:0] a1 = a + 1'b1;
    logic [DW-1:0] d0 = DW'($urandom);
    logic [DW-1:0] d1 = ~ref_mem[a1];
    handshake(1'b1, a, 4'd3);
    hif.wr_valid = 1'b1; hif.wr_data = d0; t = 0;
    while (!hif.wr_ready && t < 64) begin @(negedge clk); t++; end
    @(negedge clk);
    hif.wr_data = d1; t = 0;
    while (!hif.wr_ready && t < 64) begin @(negedge clk); t++; end
    @(negedge clk);
    hif.wr_valid = 1'b0;
    dc0 = done_cnt;
    n_tests++;
    if (ram_wa !== 1'b1) begin n_fail++; $display("FAIL mid_setup: ram_wa=%b required 1 before reset", ram_wa); end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({ram_cs, ram_oa, ram_wa, hif.busy, hif.req_ready, hif.wr_ready} !== 6'b0) begin
      n_fail++; $display("FAIL mid_async: cs=%b oa=%b wa=%b busy=%b rdy=%b wrdy=%b required all 0",
                         ram_cs, ram_oa, ram_wa, hif.busy, hif.req_ready, hif.wr_ready);
    end
    ref_mem[a] = d0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if (mem[a] !== d0 || mem[a1] !== ref_mem[a1] || done_cnt != dc0) begin
      n_fail++; $display("FAIL mid_abort: ram[a]=%h ram[a+1]=%h done=%0d required %h %h 0",
                         mem[a], mem[a1], done_cnt - dc0, d0, ref_mem[a1]);
    end
  endtask

  task automatic test_random();
    int gv; int bad;
    for (int k = 0; k < 30; k++) begin
      logic [AW-1:0] a = AW'($urandom_range(0, DEPTH - 1));
      logic [AW-1:0] l = AW'($urandom_range(0, DEPTH - 1));
      if ($urandom_range(0, 1) == 1) begin
        wr_q = {};
        for (int i = 0; i <= int'(l); i++) wr_q.push_back(DW'($urandom));
        do_write(a, l, $urandom_range(0, 2), gv);
      end else begin
        do_read(a, l);
        bad = (rd_got.size() != int'(l) + 1) ? 1 : 0;
        for (int i = 0; i < rd_got.size(); i++)
          if (rd_got[i] !== ref_mem[AW'(int'(a) + i)] || rd_idx[i] != 2 + i) bad++;
        n_tests++;
        if (bad != 0) begin
          n_fail++; $display("FAIL rand_read %0d: addr=%h len=%0d beats=%0d errors=%0d required %0d 0",
                             k, a, l, rd_got.size(), bad, int'(l) + 1);
        end
      end
    end
    bad = 0;
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== ref_mem[i]) bad++;
    n_tests++;
    if (bad != 0) begin n_fail++; $display("FAIL rand_contents: differing words=%0d required 0", bad); end
  endtask

  initial begin
    hif.req_valid = 1'b0; hif.req_write = 1'b0; hif.req_addr = '0; hif.req_len = '0;
    hif.wr_valid = 1'b0; hif.wr_data = '0;
    for (int i = 0; i < DEPTH; i++) begin mem[i] = DW'($urandom); ref_mem[i] = mem[i]; end
    test_reset();
    test_single();
    test_wrap();
    test_gaps();
    test_ignore_wr();
    test_full_busy();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
